instr_fetch: RTL and testbench

Instruction fetch stage of the MIPS core. Drives instruction-memory requests from a program counter and buffers returned words in a 2-entry output queue (output register plus skid). Presents one instruction word with its PC to the decode/control unit through a valid/ready handshake. Accepts branch/jump redirects from downstream and discards wrong-path fetches.

---
 rtl/mips_pkg.sv | 39 +++
 rtl/if_skid_buffer.sv | 66 ++++++
 rtl/instr_fetch.sv | 159 +++++++++++++++
 tb/tb_instr_fetch.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared across the MIPS core.
//   - MIPS_NOP / DEFAULT_RESET_PC constants
//   - if_state_t: fetch-stage FSM states
//   - if_entry_t: {instr, pc} entry held by the fetch output queue
//   - primary opcode constants used by the control unit
//   - word_align(): clears the byte-offset bits of an address
`timescale 1ns/1ps
package mips_pkg;

  localparam logic [31:0] MIPS_NOP         = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // ERR is only reachable when alignment checking is built in.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } if_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } if_entry_t;

  // Primary opcodes (instr[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_skid_buffer.sv
// if_skid_buffer: 2-entry FIFO (output register + skid) for fetched words.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   flush            discard all entries; a push in the same cycle still lands
//   push, push_data  write one entry (caller guarantees count < 2)
//   pop              remove the head entry (ignored when empty)
//   count            current occupancy, 0..2
//   head             oldest entry (contents meaningless when count == 0)
`timescale 1ns/1ps
module if_skid_buffer #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   count,
  output logic [W-1:0] head
);

  logic [W-1:0] entry0;   // head
  logic [W-1:0] entry1;   // skid
  logic [1:0]   occupancy;
  logic         pop_eff;

  assign pop_eff = pop && (occupancy != 2'd0);
  assign count   = occupancy;
  assign head    = entry0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy <= 2'd0;
      entry0    <= '0;
      entry1    <= '0;
    end else if (flush) begin
      // Flush empties the queue, but a simultaneous push becomes the new head.
      occupancy <= push ? 2'd1 : 2'd0;
      if (push) entry0 <= push_data;
    end else begin
      case ({push, pop_eff})
        2'b10: begin
          if (occupancy == 2'd0) entry0 <= push_data;
          else                   entry1 <= push_data;
          occupancy <= occupancy + 2'd1;
        end
        2'b01: begin
          entry0    <= entry1;
          occupancy <= occupancy - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the new word lands behind whatever remains.
          if (occupancy == 2'd1) begin
            entry0 <= push_data;
          end else begin
            entry0 <= entry1;
            entry1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: MIPS instruction fetch stage.
// Issues one instruction-memory request at a time from the program counter,
// queues returned words in a 2-entry buffer and hands them to decode over a
// valid/ready handshake. Redirects flush the queue and discard the response
// of any request already in flight.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   imem_req/imem_addr/imem_gnt         request channel (one outstanding max)
//   imem_rvalid/imem_rdata              in-order response channel
//   redirect/redirect_pc                branch taken / jump target
//   id_ready                            decode accepts the current word
//   if_valid/instrucao/pc_out/pc_plus4  word to decode with its address
//   if_misaligned                       only with IF_ALIGN_CHECK_EN
// Build option: define IF_ALIGN_CHECK_EN to trap misaligned redirect targets
// (ERR state, one flagged NOP entry). Without it the low target bits are
// simply forced to zero.
`timescale 1ns/1ps
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] instrucao,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4
`ifdef IF_ALIGN_CHECK_EN
  ,
  output logic        if_misaligned
`endif
);

`ifdef IF_ALIGN_CHECK_EN
  localparam int ENTRY_W = 65;   // {misaligned, instr, pc}
`else
  localparam int ENTRY_W = 64;   // {instr, pc}
`endif

  if_state_t            state_reg;
  if_state_t            state_next;
  logic [31:0]          pc;
  logic                 outst;
  logic                 drop;
  logic [31:0]          inflight_pc;

  logic                 grant;
  logic                 q_push;
  logic [ENTRY_W-1:0]   q_push_data;
  logic                 q_pop;
  logic [1:0]           q_count;
  logic [ENTRY_W-1:0]   q_head;
  if_entry_t            head_entry;
  if_entry_t            fetched_entry;
  logic                 fetch_push;

  assign grant      = imem_req && imem_gnt;
  assign imem_addr  = pc;
  // A response that coincides with a redirect belongs to the old path.
  assign fetch_push = imem_rvalid && !drop && !redirect;
  assign fetched_entry = '{instr: imem_rdata, pc: inflight_pc};

`ifdef IF_ALIGN_CHECK_EN
  logic mis_redirect;
  assign mis_redirect = redirect && (redirect_pc[1:0] != 2'b00);
  assign q_push       = fetch_push || mis_redirect;
  assign q_push_data  = mis_redirect ? {1'b1, MIPS_NOP, redirect_pc}
                                     : {1'b0, fetched_entry};
`else
  assign q_push       = fetch_push;
  assign q_push_data  = fetched_entry;
`endif

  assign q_pop = if_valid && id_ready;

  if_skid_buffer #(.W(ENTRY_W)) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .push      (q_push),
    .push_data (q_push_data),
    .pop       (q_pop),
    .count     (q_count),
    .head      (q_head)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = state_reg;
    endcase
`ifdef IF_ALIGN_CHECK_EN
    if (redirect) state_next = mis_redirect ? ERR : RUN;
`endif
  end

  // ---------------- FSM: outputs ----------------
  // Once raised, the request inputs (outst, occupancy) cannot change until a
  // grant or a redirect, so the address stays stable while ungranted.
  always_comb begin
    imem_req = (state_reg == RUN) && !outst && (q_count != 2'd2);
  end

  // ---------------- PC / outstanding / drop tracking ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      outst       <= 1'b0;
      drop        <= 1'b0;
      inflight_pc <= RESET_PC;
    end else begin
      if (grant) begin
        outst       <= 1'b1;
        inflight_pc <= pc;
      end else if (imem_rvalid) begin
        outst <= 1'b0;
      end

      if (redirect) begin
        pc   <= word_align(redirect_pc);
        // Something still to come back from the old path must be discarded;
        // a response arriving right now is already being dropped.
        drop <= grant || (outst && !imem_rvalid);
      end else begin
        if (grant) pc <= pc + 32'd4;
        if (imem_rvalid && drop) drop <= 1'b0;
      end
    end
  end

  // ---------------- Output view of the queue head ----------------
  assign head_entry = q_head[63:0];
  assign if_valid   = (q_count != 2'd0);
  assign instrucao  = if_valid ? head_entry.instr : MIPS_NOP;
  assign pc_out     = if_valid ? head_entry.pc : 32'h0;
  assign pc_plus4   = if_valid ? (head_entry.pc + 32'd4) : 32'h0;
`ifdef IF_ALIGN_CHECK_EN
  assign if_misaligned = if_valid && q_head[64];
`endif

endmodule

// File: tb/tb_instr_fetch.sv
`timescale 1ns/1ps
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_ready = 1'b0;
  logic        if_valid;
  logic [31:0] instrucao;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        mis_obs;

  int n_pass  = 0;
  int n_total = 0;
  int budget  = 0;   // number of requests the memory model will still grant
  int lat     = 1;   // memory response latency in cycles

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        mis;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];

  assign imem_gnt = (budget != 0);

  instr_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_ready    (id_ready),
    .if_valid    (if_valid),
    .instrucao   (instrucao),
    .pc_out      (pc_out),
    .pc_plus4    (pc_plus4)
`ifdef IF_ALIGN_CHECK_EN
    ,
    .if_misaligned (mis_obs)
`endif
  );

`ifndef IF_ALIGN_CHECK_EN
  assign mis_obs = 1'b0;
`endif

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic exp_push(input logic [31:0] instr, input logic [31:0] pc,
                          input logic [31:0] pc4, input logic mis);
    exp_t e;
    e.instr = instr; e.pc = pc; e.pc4 = pc4; e.mis = mis;
    exp_q.push_back(e);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // Instruction memory model: one request at a time, fixed latency.
  logic        pend = 1'b0;
  logic [31:0] paddr = 32'h0;
  int          wait_left = 0;
  always @(posedge clk) begin : mem_model
    logic        g;
    logic [31:0] a;
    g = imem_req && imem_gnt && rst_n;
    a = imem_addr;
    #1;
    imem_rvalid = 1'b0;
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (g) begin
        budget--;
        if (addr_q.size() == 0) begin
          n_total++;
          $display("FAIL grant: unexpected request granted at %h", a);
        end else begin
          chk("grant_addr", a, addr_q.pop_front());
        end
        pend = 1'b1;
        paddr = a;
        wait_left = lat - 1;
      end else if (pend && wait_left > 0) begin
        wait_left--;
      end
      if (pend && wait_left == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(paddr);
        pend = 1'b0;
      end
    end
  end

  // Monitor: every handshake must match the next expected word.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && if_valid && id_ready) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL deliver: unexpected instr %h pc %h", instrucao, pc_out);
      end else begin
        e = exp_q.pop_front();
        if (instrucao === e.instr && pc_out === e.pc && pc_plus4 === e.pc4 && mis_obs === e.mis) begin
          n_pass++;
          $display("deliver: instr %h pc %h pc4 %h mis %b ok", instrucao, pc_out, pc_plus4, mis_obs);
        end else begin
          $display("FAIL deliver: got instr %h pc %h pc4 %h mis %b expected instr %h pc %h pc4 %h mis %b",
                   instrucao, pc_out, pc_plus4, mis_obs, e.instr, e.pc, e.pc4, e.mis);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && (exp_q.size() != 0 || addr_q.size() != 0); i++) tick();
    if (exp_q.size() != 0 || addr_q.size() != 0) begin
      n_total++;
      $display("FAIL %s_timeout: got %0d words/%0d grants pending expected 0", name, exp_q.size(), addr_q.size());
      exp_q.delete();
      addr_q.delete();
    end
    repeat (2) tick();
  endtask

  initial begin
    int found;
    // ---------------- reset values ----------------
    repeat (3) tick();
    @(negedge clk);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_instrucao", instrucao, 32'h0);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_pc_plus4", pc_plus4, 32'h0);
    chk("rst_misaligned", mis_obs, 0);

    // ---------------- streaming, 1-cycle memory ----------------
    addr_q.push_back(32'h0); addr_q.push_back(32'h4); addr_q.push_back(32'h8);
    exp_push(32'hDEAD_0000, 32'h0, 32'h4, 0);
    exp_push(32'hDEAD_0004, 32'h4, 32'h8, 0);
    exp_push(32'hDEAD_0008, 32'h8, 32'hC, 0);
    id_ready = 1'b1;
    budget = 3;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_no_req", imem_req, 0);
    @(negedge clk);
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 32'h0);
    drain("stream");

    // ---------------- back-pressure ----------------
    id_ready = 1'b0;
    addr_q.push_back(32'hC); addr_q.push_back(32'h10);
    exp_push(32'hDEAD_000C, 32'hC, 32'h10, 0);
    exp_push(32'hDEAD_0010, 32'h10, 32'h14, 0);
    budget = 2;
    repeat (8) tick();
    @(negedge clk);
    chk("full_no_req", imem_req, 0);
    chk("full_valid", if_valid, 1);
    chk("full_head_pc", pc_out, 32'hC);
    tick();
    id_ready = 1'b1;
    drain("backpressure");

    // ---------------- redirect with a request outstanding ----------------
    lat = 3;
    addr_q.push_back(32'h14); addr_q.push_back(32'h100); addr_q.push_back(32'h104);
    exp_push(32'hDEAD_0100, 32'h100, 32'h104, 0);
    exp_push(32'hDEAD_0104, 32'h104, 32'h108, 0);
    budget = 1;
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    budget = 2;
    @(negedge clk);
    chk("redir_addr", imem_addr, 32'h100);
    chk("redir_pending_no_req", imem_req, 0);
    drain("redirect_outst");

    // ---------------- redirect coinciding with the response ----------------
    addr_q.push_back(32'h108); addr_q.push_back(32'h200);
    exp_push(32'hDEAD_0200, 32'h200, 32'h204, 0);
    budget = 1;
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      tick();
      if (imem_rvalid) found = 1;
    end
    chk("rvalid_seen", found, 1);
    redirect = 1'b1;
    redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    budget = 1;
    @(negedge clk);
    chk("redir_rvalid_no_valid", if_valid, 0);
    drain("redirect_rvalid");

    // ---------------- PC wrap ----------------
    lat = 1;
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    addr_q.push_back(32'hFFFF_FFFC); addr_q.push_back(32'h0);
    exp_push(32'h2152_FFFC, 32'hFFFF_FFFC, 32'h0, 0);
    exp_push(32'hDEAD_0000, 32'h0, 32'h4, 0);
    budget = 2;
    @(negedge clk);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_req", imem_req, 1);
    drain("wrap");

    // ---------------- asynchronous reset mid-operation ----------------
    id_ready = 1'b0;
    addr_q.push_back(32'h4);
    budget = 1;
    repeat (5) tick();
    @(negedge clk);
    chk("pre_rst_valid", if_valid, 1);
    chk("pre_rst_pc", pc_out, 32'h4);
    tick();
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", if_valid, 0);
    chk("async_rst_req", imem_req, 0);
    chk("async_rst_addr", imem_addr, 32'h0);
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    id_ready = 1'b1;
    addr_q.push_back(32'h0);
    exp_push(32'hDEAD_0000, 32'h0, 32'h4, 0);
    budget = 1;
    drain("after_reset");

`ifdef IF_ALIGN_CHECK_EN
    // ---------------- misaligned redirect trap ----------------
    redirect = 1'b1;
    redirect_pc = 32'h102;
    exp_push(32'h0, 32'h102, 32'h106, 1);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    chk("err_misaligned", mis_obs, 1);
    chk("err_no_req", imem_req, 0);
    repeat (4) tick();
    @(negedge clk);
    chk("err_still_no_req", imem_req, 0);
    tick();
    addr_q.push_back(32'h200);
    exp_push(32'hDEAD_0200, 32'h200, 32'h204, 0);
    budget = 1;
    redirect = 1'b1;
    redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    drain("err_recover");
`else
    // ---------------- low target bits forced to zero ----------------
    redirect = 1'b1;
    redirect_pc = 32'h303;
    tick();
    redirect = 1'b0;
    addr_q.push_back(32'h300);
    exp_push(32'hDEAD_0300, 32'h300, 32'h304, 0);
    @(negedge clk);
    chk("align_force_addr", imem_addr, 32'h300);
    tick();
    budget = 1;
    drain("align_force");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
